// File: rtl/seg_scan_drv.sv
// Four-digit multiplexed seven-segment driver: clamps a binary value to 9999,
// converts it to BCD once per frame (double-dabble) and scans digits with per-digit blanking.
module seg_scan_drv #(
    parameter int DIV_CNT  = 50000,
    parameter int DP_DIGIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num,
    input  logic [3:0]  en,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int             PW         = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV_CNT - 1);
    localparam logic [3:0]     LAST_ITER  = 4'd13;
    localparam bit             DP_ON      = (DP_DIGIT >= 0) && (DP_DIGIT < 4);
    localparam logic [1:0]     DP_IDX     = DP_DIGIT[1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_dig;
    logic [1:0]    r_state;
    logic [3:0]    r_iter;
    logic [13:0]   r_bin;
    logic [15:0]   r_bcd;
    logic [15:0]   r_disp;
    logic [7:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_ft;

    logic          w_slot_end;
    logic          w_frame_start;
    logic [13:0]   w_num_clamped;
    logic [15:0]   w_bcd_adj;
    logic [15:0]   w_bcd_next;
    logic [13:0]   w_bin_next;
    logic [3:0]    w_nib;
    logic          w_en_cur;
    logic          w_dp;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign w_slot_end    = (r_presc == PRESC_LAST);
    assign w_frame_start = (r_presc == '0) && (r_dig == 2'd0);
    assign w_num_clamped = (num > 32'd9999) ? 14'd9999 : num[13:0];

    // Add-3 correction precedes the shift in every iteration
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign {w_bcd_next, w_bin_next} = {w_bcd_adj[14:0], r_bin, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_dig   <= 2'd0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_dig   <= r_dig + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iter  <= 4'd0;
            r_bin   <= 14'd0;
            r_bcd   <= 16'd0;
            r_disp  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_frame_start) begin
                        r_bin   <= w_num_clamped;
                        r_bcd   <= 16'd0;
                        r_iter  <= 4'd0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    if (r_iter == LAST_ITER)
                        r_state <= S_LOAD;
                    else
                        r_iter <= r_iter + 4'd1;
                end
                S_LOAD: begin
                    r_disp  <= r_bcd;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_dig)
            2'd0:    w_nib = r_disp[3:0];
            2'd1:    w_nib = r_disp[7:4];
            2'd2:    w_nib = r_disp[11:8];
            default: w_nib = r_disp[15:12];
        endcase
    end

    // The mask is taken live so blanking follows en with a single register of lag
    assign w_en_cur = en[r_dig];
    assign w_dp     = DP_ON && (r_dig == DP_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 8'd0;
            r_an  <= 4'd0;
            r_ft  <= 1'b0;
        end else begin
            r_an  <= w_en_cur ? (4'b0001 << r_dig) : 4'b0000;
            r_seg <= w_en_cur ? {w_dp, seg7(w_nib)} : 8'd0;
            r_ft  <= w_frame_start;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_ft;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv: stimulus queues hand-computed per-slot
// expectations, a negedge monitor pops them mid-slot and checks frame period.
module tb_seg_scan_drv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] num = 32'd0;
    logic [3:0]  en  = 4'd0;
    logic [7:0]  seg, seg_b;
    logic [3:0]  an, an_b;
    logic        ft, ft_b;

    seg_scan_drv #(.DIV_CNT(16), .DP_DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .num(num), .en(en),
        .seg(seg), .an(an), .frame_tick(ft)
    );

    seg_scan_drv #(.DIV_CNT(16), .DP_DIGIT(1)) u_dut_dp1 (
        .clk(clk), .rst(rst), .num(num), .en(en),
        .seg(seg_b), .an(an_b), .frame_tick(ft_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [7:0] seg_b;
        string      tag;
        int         slot;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   phase = 0;
    int   cyc   = 0;
    int   last_ft = -1;

    // Monitor: mid-slot sample of both instances, plus frame period
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            last_ft = -1;
            phase++;
        end else if (ft) begin
            if (last_ft >= 0) begin
                n_vec++;
                if (cyc - last_ft != 64 || ft_b !== 1'b1) begin
                    n_bad++;
                    $display("FAIL frame_period: got %0d cycles (dp1 tick=%b), expected 64", cyc - last_ft, ft_b);
                end
            end
            last_ft = cyc;
            phase = 0;
        end else begin
            phase++;
        end
        if (!rst && (phase % 16) == 8 && q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (an !== e.an || seg !== e.seg || an_b !== e.an || seg_b !== e.seg_b) begin
                n_bad++;
                $display("FAIL %s slot%0d: an=%b seg=%h dp1_an=%b dp1_seg=%h, expected an=%b seg=%h dp1_seg=%h",
                         e.tag, e.slot, an, seg, an_b, seg_b, e.an, e.seg, e.seg_b);
            end
        end
    end

    task automatic wait_ft();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ft && k < 200);
        if (!ft) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_tick_timeout: no tick within %0d cycles, expected one per 64", k);
        end
    endtask

    // Each v is {an, seg}; the DP_DIGIT=1 instance additionally lights dp on digit 1
    task automatic push4(input string tag, input logic [11:0] v0, input logic [11:0] v1,
                         input logic [11:0] v2, input logic [11:0] v3);
        logic [11:0] v[4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.an    = v[i][11:8];
            e.seg   = v[i][7:0];
            e.seg_b = v[i][9] ? (v[i][7:0] | 8'h80) : v[i][7:0];
            e.tag   = tag;
            e.slot  = i;
            q.push_back(e);
        end
    endtask

    task automatic check1(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a frame_tick negedge; returns at a later frame_tick negedge
    task automatic run(input string tag, input logic [31:0] n, input logic [3:0] m,
                       input logic [11:0] v0, input logic [11:0] v1,
                       input logic [11:0] v2, input logic [11:0] v3);
        num = n;
        en  = m;
        wait_ft();
        wait_ft();
        push4(tag, v0, v1, v2, v3);
        wait_ft();
    endtask

    initial begin
        int k;
        rst = 1'b1;
        num = 32'd1234;
        en  = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_an",  {4'd0, an}, 8'h00);
        check1("reset_seg", seg, 8'h00);
        check1("reset_ft",  {7'd0, ft}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check1("first_tick", {7'd0, ft}, 8'h01);
        // Display registers start at zero, so digit 0 is stale for the first frame
        push4("first_frame", 12'h1_3F, 12'h2_4F, 12'h4_5B, 12'h8_06);
        wait_ft();
        push4("n1234", 12'h1_66, 12'h2_4F, 12'h4_5B, 12'h8_06);
        wait_ft();

        run("n7_en0001",    32'd7,      4'b0001, 12'h1_07, 12'h0_00, 12'h0_00, 12'h0_00);
        run("n100000",      32'd100000, 4'b1111, 12'h1_6F, 12'h2_6F, 12'h4_6F, 12'h8_6F);
        run("n0",           32'd0,      4'b1111, 12'h1_3F, 12'h2_3F, 12'h4_3F, 12'h8_3F);
        run("n9876",        32'd9876,   4'b1111, 12'h1_7D, 12'h2_07, 12'h4_7F, 12'h8_6F);
        run("n10000",       32'd10000,  4'b1111, 12'h1_6F, 12'h2_6F, 12'h4_6F, 12'h8_6F);
        run("n5678_en1010", 32'd5678,   4'b1010, 12'h0_00, 12'h2_07, 12'h0_00, 12'h8_6D);
        run("n42_en0011",   32'd42,     4'b0011, 12'h1_5B, 12'h2_66, 12'h0_00, 12'h0_00);
        run("n1234_again",  32'd1234,   4'b1111, 12'h1_66, 12'h2_4F, 12'h4_5B, 12'h8_06);

        // num changes during the 5th SHIFT cycle: this frame keeps 1234
        repeat (4) @(negedge clk);
        num = 32'd5678;
        push4("midshift_hold", 12'h1_66, 12'h2_4F, 12'h4_5B, 12'h8_06);
        wait_ft();
        push4("midshift_next", 12'h1_66, 12'h2_07, 12'h4_7D, 12'h8_6D);
        wait_ft();
        push4("midshift_full", 12'h1_7F, 12'h2_07, 12'h4_7D, 12'h8_6D);
        wait_ft();

        // Reset in the middle of a conversion
        num = 32'd4321;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check1("midrst_an",  {4'd0, an}, 8'h00);
        check1("midrst_seg", seg, 8'h00);
        check1("midrst_ft",  {7'd0, ft}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("rst_release_tick", {7'd0, ft}, 8'h01);
        push4("post_rst_first", 12'h1_3F, 12'h2_5B, 12'h4_4F, 12'h8_66);
        wait_ft();
        push4("post_rst_full",  12'h1_06, 12'h2_5B, 12'h4_4F, 12'h8_66);
        wait_ft();

        k = 0;
        while (q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
